apple_bus_read_responder: RTL and testbench
===========================================

Name: apple_bus_read_responder

Overview:
- Slot-card read responder: the driving counterpart of the bus sampler. It decodes sampled Apple II read cycles aimed at this card's slot space and fetches a byte from an internal source over a req/ack handshake.
- It drives that byte onto the Apple II data bus through the external transceiver during Phi0, with a controlled enable and hold window.
- Sits between the a2bus timing/sampling logic and the card's ROM/register file.

Parameters:
- DRIVE_COUNT, 2, clk_logic cycles after phi0 rising edge at which the data bus drive begins.
- HOLD_COUNT, 2, clk_logic cycles after phi0 falling edge for which the drive is held (must be < 18).
- ENABLE_IOSEL, 1, 1 = respond to $Cn00-$CnFF as well as $C0n0-$C0nF.

Ports:
- clk_logic_i  in  1  logic clock (54 MHz).
- system_reset_n_i  in  1  asynchronous active-low reset.
- enable_i  in  1  responder enable.
- slot_i  in  3  slot number n, 1-7; 0 disables decoding.
- phi0_posedge_i  in  1  one-cycle strobe, Phi0 rising.
- phi0_negedge_i  in  1  one-cycle strobe, Phi0 falling.
- addr_valid_i  in  1  one-cycle strobe; addr_i/rw_n_i newly sampled this cycle (during Phi1).
- addr_i  in  16  sampled address.
- rw_n_i  in  1  sampled R/W#.
- rd_req_o  out  1  read request to internal source, level.
- rd_sel_o  out  1  0 = DEVSEL space, 1 = IOSEL space.
- rd_addr_o  out  8  offset within space (DEVSEL: upper nibble 0).
- rd_ack_i  in  1  one-cycle strobe, rd_data_i valid.
- rd_data_i  in  8  read data.
- a2_d_o  out  8  data to bus transceiver.
- a2_d_oe_n_o  out  1  transceiver output enable, active low.
- late_o  out  1  one-cycle pulse: ack missed the drive point.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous): state IDLE, rd_req_o=0, rd_sel_o=0, rd_addr_o=0, a2_d_o=8'h00, a2_d_oe_n_o=1, late_o=0.
- Decode, evaluated only on addr_valid_i in IDLE. A hit requires enable_i=1, rw_n_i=1, slot_i!=0, and one of:
  - DEVSEL hit: addr_i[15:4] == {8'hC0, 1'b1, slot_i}.
  - IOSEL hit: ENABLE_IOSEL=1 and addr_i[15:8] == {5'b11000, slot_i}.
- Writes, misses and slot 0 leave the block in IDLE.
- phase counter: 4-bit, cleared on phi0_posedge_i, saturating increment; a separate hold counter is cleared on phi0_negedge_i.
- States:
  - IDLE:
    - Decode hit -> REQ next cycle.
    - rd_req_o=1, rd_sel_o and rd_addr_o registered from addr_i.
  - REQ:
    - Wait for rd_ack_i.
    - On ack, capture rd_data_i into a2_d_o, drop rd_req_o -> READY.
    - If the phase counter reaches DRIVE_COUNT (after a phi0_posedge_i) with no ack: pulse late_o, drop rd_req_o -> IDLE, no drive this cycle.
  - READY:
    - When the phase counter == DRIVE_COUNT during Phi0: a2_d_oe_n_o=0 -> DRIVE.
    - An ack arriving in the same cycle as the deadline counts as on time.
  - DRIVE:
    - a2_d_o held stable.
    - On phi0_negedge_i -> HOLD.
  - HOLD:
    - After HOLD_COUNT cycles: a2_d_oe_n_o=1 -> IDLE.
- Latency: decode hit to rd_req_o is 1 cycle. Drive begins exactly DRIVE_COUNT+1 cycles after the phi0_posedge_i strobe. Release follows HOLD_COUNT+1 cycles after the phi0_negedge_i strobe.
- rd_ack_i outside REQ is ignored.
- addr_valid_i outside IDLE is ignored.
- enable_i falling in any state: next cycle rd_req_o=0, a2_d_oe_n_o=1, -> IDLE; no late_o pulse.
- slot_i changes take effect only at the next decode.
- a2_d_oe_n_o is never low outside DRIVE/HOLD; a2_d_o keeps its last value when not driving.

Test Plan:
- slot_i=5, addr_valid_i with addr 16'hC0D3, rw_n_i=1 -> rd_req_o=1 next cycle, rd_sel_o=0, rd_addr_o=8'h03. Ack with 8'hA5 before Phi0 -> a2_d_o=8'hA5, oe_n low at phi0_posedge+3 cycles, high at phi0_negedge+3 cycles.
- slot_i=5, addr 16'hC512 -> rd_sel_o=1, rd_addr_o=8'h12. With ENABLE_IOSEL=0 -> no request, oe_n stays 1.
- Write cycle to 16'hC0D0 (rw_n_i=0), and a read of 16'hC0E0 with slot 5 -> no request, busy_o=0.
- Ack withheld until phase count 3 -> late_o one-cycle pulse at count 2, oe_n stays 1, state IDLE; the later ack is ignored.
- enable_i dropped mid-DRIVE -> oe_n=1 next cycle, IDLE. Reset asserted mid-DRIVE -> oe_n=1 immediately, without waiting for a clock edge.
- Back-to-back read hits on consecutive bus cycles -> each is driven; oe_n rises during HOLD before the next addr_valid_i.

Source files
------------

// File: rtl/apple_bus_read_responder.sv
// Apple II slot-card read responder.
// Decodes sampled read cycles aimed at this card's DEVSEL ($C0n0-$C0nF) or
// IOSEL ($Cn00-$CnFF) space and fetches a byte over a req/ack handshake.
// It then drives that byte onto the bus transceiver for a fixed window
// inside Phi0.
module apple_bus_read_responder #(
    parameter int DRIVE_COUNT  = 2,    // phase count (after Phi0 rise) at which drive begins
    parameter int HOLD_COUNT   = 2,    // cycles after Phi0 fall the drive is held, < 18
    parameter bit ENABLE_IOSEL = 1'b1  // also answer $Cn00-$CnFF
) (
    input  logic        clk_logic_i,
    input  logic        system_reset_n_i,
    input  logic        enable_i,
    input  logic [2:0]  slot_i,
    input  logic        phi0_posedge_i,
    input  logic        phi0_negedge_i,
    input  logic        addr_valid_i,
    input  logic [15:0] addr_i,
    input  logic        rw_n_i,
    output logic        rd_req_o,
    output logic        rd_sel_o,
    output logic [7:0]  rd_addr_o,
    input  logic        rd_ack_i,
    input  logic [7:0]  rd_data_i,
    output logic [7:0]  a2_d_o,
    output logic        a2_d_oe_n_o,
    output logic        late_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        READY = 3'd2,
        DRIVE = 3'd3,
        HOLD  = 3'd4
    } state_t;

    // Request toward the internal byte source.
    typedef struct packed {
        logic       req;
        logic       sel;   // 0 = DEVSEL, 1 = IOSEL
        logic [7:0] addr;
    } rd_req_t;

    // The phase counter saturates at 15, so DRIVE_COUNT is kept below that
    // to make the deadline a single-cycle event per Phi0.
    localparam logic [3:0] DRIVE_CNT = 4'(DRIVE_COUNT);
    localparam logic [4:0] HOLD_CNT  = 5'(HOLD_COUNT);

    state_t      state_q, state_d;
    rd_req_t     req_q, req_d;
    logic [7:0]  a2_d_q, a2_d_d;
    logic        oe_n_q, oe_n_d;
    logic        late_q, late_d;

    logic [3:0]  phase_q, phase_d;
    logic [4:0]  hold_q, hold_d;
    logic        in_phi0_q, in_phi0_d;

    logic        dev_hit;
    logic        io_hit;
    logic        hit;
    logic        deadline;

    // Phase / hold counters and Phi0 window tracking.
    always_comb begin
        phase_d = phase_q;
        if (phi0_posedge_i) begin
            phase_d = '0;
        end else if (phase_q != 4'hF) begin
            phase_d = phase_q + 4'd1;
        end

        hold_d = hold_q;
        if (phi0_negedge_i) begin
            hold_d = '0;
        end else if (hold_q != 5'h1F) begin
            hold_d = hold_q + 5'd1;
        end

        in_phi0_d = in_phi0_q;
        if (phi0_posedge_i) begin
            in_phi0_d = 1'b1;
        end else if (phi0_negedge_i) begin
            in_phi0_d = 1'b0;
        end
    end

    // Address decode; only meaningful while IDLE on an addr_valid_i strobe.
    always_comb begin
        dev_hit  = (addr_i[15:4] == {8'hC0, 1'b1, slot_i});
        io_hit   = ENABLE_IOSEL && (addr_i[15:8] == {5'b11000, slot_i});
        hit      = addr_valid_i && enable_i && rw_n_i && (slot_i != 3'd0)
                   && (dev_hit || io_hit);
        // Deadline: phase count has reached the drive point within this Phi0.
        deadline = in_phi0_q && (phase_q == DRIVE_CNT);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        a2_d_d  = a2_d_q;
        oe_n_d  = oe_n_q;
        late_d  = 1'b0;

        if (!enable_i) begin
            // Disable wins everywhere: release the bus and drop any request.
            state_d   = IDLE;
            req_d.req = 1'b0;
            oe_n_d    = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    req_d.req = 1'b0;
                    oe_n_d    = 1'b1;
                    if (hit) begin
                        state_d    = REQ;
                        req_d.req  = 1'b1;
                        req_d.sel  = ~dev_hit;
                        req_d.addr = dev_hit ? {4'h0, addr_i[3:0]} : addr_i[7:0];
                    end
                end
                REQ: begin
                    if (rd_ack_i) begin
                        a2_d_d    = rd_data_i;
                        req_d.req = 1'b0;
                        // An ack landing on the deadline is on time: drive now
                        // so the drive point is not missed.
                        if (deadline) begin
                            oe_n_d  = 1'b0;
                            state_d = DRIVE;
                        end else begin
                            state_d = READY;
                        end
                    end else if (deadline) begin
                        late_d    = 1'b1;
                        req_d.req = 1'b0;
                        state_d   = IDLE;
                    end
                end
                READY: begin
                    if (deadline) begin
                        oe_n_d  = 1'b0;
                        state_d = DRIVE;
                    end
                end
                DRIVE: begin
                    if (phi0_negedge_i) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (hold_q == HOLD_CNT) begin
                        oe_n_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    req_d.req = 1'b0;
                    oe_n_d    = 1'b1;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
        if (!system_reset_n_i) begin
            state_q   <= IDLE;
            req_q     <= '0;
            a2_d_q    <= 8'h00;
            oe_n_q    <= 1'b1;
            late_q    <= 1'b0;
            phase_q   <= '0;
            hold_q    <= '0;
            in_phi0_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            a2_d_q    <= a2_d_d;
            oe_n_q    <= oe_n_d;
            late_q    <= late_d;
            phase_q   <= phase_d;
            hold_q    <= hold_d;
            in_phi0_q <= in_phi0_d;
        end
    end

    assign rd_req_o    = req_q.req;
    assign rd_sel_o    = req_q.sel;
    assign rd_addr_o   = req_q.addr;
    assign a2_d_o      = a2_d_q;
    assign a2_d_oe_n_o = oe_n_q;
    assign late_o      = late_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_apple_bus_read_responder.sv
// Bench for apple_bus_read_responder: directed bus cycles plus randomized
// ones, each checked step by step against a timeline model of the response.
module tb_apple_bus_read_responder;

    localparam int D = 2;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, en_b;
    logic [2:0]  slot;
    logic        pp, pn, av, rw, ack;
    logic [15:0] addr;
    logic [7:0]  rdata;

    logic        req, sel, oe_n, late, busy;
    logic [7:0]  raddr, a2d;
    logic        b_req, b_sel, b_oe_n, b_late, b_busy;
    logic [7:0]  b_raddr, b_a2d;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    logic [7:0] last_d;

    always #5 clk = ~clk;

    apple_bus_read_responder #(.DRIVE_COUNT(D), .HOLD_COUNT(H), .ENABLE_IOSEL(1'b1)) dut (
        .clk_logic_i(clk), .system_reset_n_i(rst_n), .enable_i(en), .slot_i(slot),
        .phi0_posedge_i(pp), .phi0_negedge_i(pn), .addr_valid_i(av), .addr_i(addr),
        .rw_n_i(rw), .rd_req_o(req), .rd_sel_o(sel), .rd_addr_o(raddr),
        .rd_ack_i(ack), .rd_data_i(rdata), .a2_d_o(a2d), .a2_d_oe_n_o(oe_n),
        .late_o(late), .busy_o(busy));

    apple_bus_read_responder #(.DRIVE_COUNT(D), .HOLD_COUNT(H), .ENABLE_IOSEL(1'b0)) dut_b (
        .clk_logic_i(clk), .system_reset_n_i(rst_n), .enable_i(en_b), .slot_i(slot),
        .phi0_posedge_i(pp), .phi0_negedge_i(pn), .addr_valid_i(av), .addr_i(addr),
        .rw_n_i(rw), .rd_req_o(b_req), .rd_sel_o(b_sel), .rd_addr_o(b_raddr),
        .rd_ack_i(ack), .rd_data_i(rdata), .a2_d_o(b_a2d), .a2_d_oe_n_o(b_oe_n),
        .late_o(b_late), .busy_o(b_busy));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One logic-clock step: drive strobes, let the DUT clock them, sample at negedge.
    task automatic cyc(input logic v, input logic a_ck, input logic p_p, input logic p_n);
        av = v; ack = a_ck; pp = p_p; pn = p_n;
        @(posedge clk);
        @(negedge clk);
        av = 1'b0; ack = 1'b0; pp = 1'b0; pn = 1'b0;
    endtask

    // One Apple II bus cycle. Steps: A = addr_valid, K = ack (-1 none),
    // P = Phi0 rise, N = Phi0 fall, E = enable drops (-1 never).
    task automatic bus(input string nm, input logic [15:0] a, input logic w_rd,
                       input logic [2:0] s, input int A, input int K, input int P,
                       input int N, input int E, input logic [7:0] dat);
        int   dl, req_end, busy_end;
        bit   en_at_a, dev, io, hit, ok, off;
        bit   e_req, e_busy, e_late, e_drv;
        logic [7:0] e_d, e_addr;
        dl       = P + D + 1;
        en_at_a  = (E < 0) || (A < E);
        dev      = ({16'h0, a} >> 4) == (32'h0C08 + {29'h0, s});
        io       = ({16'h0, a} >> 8) == (32'h00C0 + {29'h0, s});
        hit      = en_at_a && w_rd && (s != 3'd0) && (dev || io);
        ok       = hit && (K > A) && (K <= dl) && ((E < 0) || (K < E));
        req_end  = ok ? K : dl;
        busy_end = ok ? N + H + 1 : dl;
        e_addr   = a[7:0] & (dev ? 8'h0F : 8'hFF);
        addr = a; rw = w_rd; slot = s; rdata = dat;
        for (int k = 0; k < N + H + 4; k++) begin
            en = (E < 0) || (k < E);
            cyc(k == A, k == K, k == P, k == N);
            off    = (E >= 0) && (k >= E);
            e_req  = !off && hit && k >= A && k < req_end;
            e_busy = !off && hit && k >= A && k < busy_end;
            e_late = !off && hit && !ok && k == dl;
            e_drv  = !off && ok && k >= dl && k < N + H + 1;
            e_d    = (ok && k >= K) ? dat : last_d;
            chk($sformatf("%s req k=%0d", nm, k),  16'(req),  16'(e_req));
            chk($sformatf("%s busy k=%0d", nm, k), 16'(busy), 16'(e_busy));
            chk($sformatf("%s late k=%0d", nm, k), 16'(late), 16'(e_late));
            chk($sformatf("%s oe_n k=%0d", nm, k), 16'(oe_n), 16'(!e_drv));
            chk($sformatf("%s data k=%0d", nm, k), 16'(a2d),  16'(e_d));
            if (e_req) begin
                chk($sformatf("%s sel k=%0d", nm, k),   16'(sel),   16'(!dev));
                chk($sformatf("%s raddr k=%0d", nm, k), 16'(raddr), 16'(e_addr));
            end
            if (en_b) begin
                chk($sformatf("%s noios req k=%0d", nm, k),  16'(b_req),  16'(0));
                chk($sformatf("%s noios oe_n k=%0d", nm, k), 16'(b_oe_n), 16'(1));
                chk($sformatf("%s noios busy k=%0d", nm, k), 16'(b_busy), 16'(0));
                chk($sformatf("%s noios late k=%0d", nm, k), 16'(b_late), 16'(0));
                chk($sformatf("%s noios regs k=%0d", nm, k),
                    {b_a2d, b_raddr[6:0], b_sel}, 16'(0));
            end
        end
        if (ok) last_d = dat;
        en = 1'b1;
    endtask

    initial begin
        logic [15:0] ra;
        logic [2:0]  rs;
        int          cat, ra_, rp, rk, rn, kc;
        rst_n = 1'b0; en = 1'b1; en_b = 1'b0; slot = 3'd0;
        pp = 0; pn = 0; av = 0; rw = 1'b1; ack = 0; addr = '0; rdata = '0;
        last_d = 8'h00;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst req",   16'(req),   16'(0));
        chk("rst sel",   16'(sel),   16'(0));
        chk("rst raddr", 16'(raddr), 16'(0));
        chk("rst data",  16'(a2d),   16'(0));
        chk("rst oe_n",  16'(oe_n),  16'(1));
        chk("rst late",  16'(late),  16'(0));
        chk("rst busy",  16'(busy),  16'(0));
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);

        // Directed cycles
        bus("devsel",  16'hC0D3, 1'b1, 3'd5, 2, 4, 8, 20, -1, 8'hA5);
        en_b = 1'b1;
        bus("iosel",   16'hC512, 1'b1, 3'd5, 2, 5, 8, 18, -1, 8'h3C);
        en_b = 1'b0;
        bus("write",   16'hC0D0, 1'b0, 3'd5, 2, 4, 8, 16, -1, 8'h11);
        bus("miss",    16'hC0E0, 1'b1, 3'd5, 2, 4, 8, 16, -1, 8'h22);
        bus("late",    16'hC0D7, 1'b1, 3'd5, 2, 14, 10, 20, -1, 8'h77);
        bus("slot0",   16'hC080, 1'b1, 3'd0, 2, 4, 8, 16, -1, 8'h33);
        bus("ontime",  16'hC0D9, 1'b1, 3'd5, 2, 11, 8, 16, -1, 8'h5E);
        bus("endrop",  16'hC0DF, 1'b1, 3'd5, 2, 4, 8, 20, 13, 8'h99);
        bus("endec",   16'hC0D1, 1'b1, 3'd5, 2, 4, 8, 16, 0, 8'h44);

        // Randomized back-to-back bus cycles
        for (int i = 0; i < 24; i++) begin
            rs  = 3'($urandom_range(7, 0));
            cat = int'($urandom_range(3, 0));
            case (cat)
                0, 3:    ra = {8'hC0, 1'b1, rs, 4'($urandom)};
                1:       ra = {5'b11000, rs, 8'($urandom)};
                default: ra = {5'b11000, 3'($urandom), 8'($urandom)};
            endcase
            ra_ = int'($urandom_range(3, 1));
            rp  = ra_ + int'($urandom_range(8, 3));
            kc  = int'($urandom_range(3, 0));
            if (kc < 2)       rk = int'($urandom_range(rp + D + 1, ra_ + 1));
            else if (kc == 2) rk = rp + D + 1 + int'($urandom_range(3, 1));
            else              rk = -1;
            rn  = rp + D + 2 + int'($urandom_range(6, 0));
            bus($sformatf("rnd%0d", i), ra, cat != 3, rs, ra_, rk, rp, rn, -1,
                8'($urandom));
        end

        // Reset asserted mid-drive releases the bus without a clock edge
        slot = 3'd5; addr = 16'hC0D1; rw = 1'b1; rdata = 8'hC3; en = 1'b1;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("prerst oe_n", 16'(oe_n), 16'(0));
        chk("prerst data", 16'(a2d),  16'hC3);
        #2 rst_n = 1'b0;
        #1;
        chk("asyncrst oe_n", 16'(oe_n), 16'(1));
        chk("asyncrst busy", 16'(busy), 16'(0));
        chk("asyncrst data", 16'(a2d),  16'(0));
        chk("asyncrst req",  16'(req),  16'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
